// File: rtl/mult_div.sv
// mult_div: multicycle signed multiply/divide unit writing the HI/LO registers.
//
// Handshake: a start is accepted only while IDLE, and start_mult wins over
// start_div. The cycle after acceptance busy rises and stays high for the
// 32 iteration cycles. Then done pulses for exactly one cycle with busy low,
// and hi/lo already hold the new result. A divide by zero skips iteration.
// It pulses done together with div_zero one cycle after the start and
// leaves hi/lo untouched. Starts seen outside IDLE are dropped.
module mult_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start_mult,
    input  logic        start_div,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Multiply: {P[63:0], q-1}. Divide: {remainder, quotient/dividend, unused}.
    logic [64:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;          // multiplicand, or divisor magnitude
    logic        q_neg_q, q_neg_d;  // quotient must be negated
    logic        r_neg_q, r_neg_d;  // remainder must be negated
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    // Booth step. The upper half is summed with one guard bit so that
    // subtracting the most negative multiplicand cannot corrupt the sign
    // that the arithmetic shift brings back in.
    logic [32:0] p_hi_ext;
    logic [32:0] booth_sum;
    logic [64:0] booth_next;

    assign p_hi_ext   = {acc_q[64], acc_q[64:33]};
    assign booth_next = {booth_sum, acc_q[32:1]};

    // Booth recoding of the {q0, q-1} pair selects add, subtract or pass.
    always_comb begin
        booth_sum = p_hi_ext;
        case (acc_q[1:0])
            2'b01:   booth_sum = p_hi_ext + {m_q[31], m_q};
            2'b10:   booth_sum = p_hi_ext - {m_q[31], m_q};
            default: booth_sum = p_hi_ext;
        endcase
    end

    // Restoring divide step on magnitudes. Shift {rem, quo} left one place
    // and subtract the divisor when the shifted remainder is large enough.
    logic        div_fits;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_lo_final;
    logic [31:0] div_hi_final;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign div_fits     = acc_q[64:32] >= {1'b0, m_q};
    assign div_rem      = div_fits ? (acc_q[63:32] - m_q) : acc_q[63:32];
    assign div_quo      = {acc_q[31:1], div_fits};
    assign div_lo_final = q_neg_q ? (~div_quo + 32'd1) : div_quo;
    assign div_hi_final = r_neg_q ? (~div_rem + 32'd1) : div_rem;
    assign a_mag        = a[31] ? (~a + 32'd1) : a;
    assign b_mag        = b[31] ? (~b + 32'd1) : b;

    // Next-state and datapath control. Every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_mult) begin
                    m_d     = a;
                    acc_d   = {32'd0, b, 1'b0};
                    cnt_d   = 5'd0;
                    state_d = S_MULT;
                end else if (start_div) begin
                    if (b != 32'd0) begin
                        m_d     = b_mag;
                        acc_d   = {32'd0, a_mag, 1'b0};
                        q_neg_d = a[31] ^ b[31];
                        r_neg_d = a[31];
                        cnt_d   = 5'd0;
                        state_d = S_DIV;
                    end else begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_MULT: begin
                acc_d = booth_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = booth_next[64:33];
                    lo_d    = booth_next[32:1];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = {div_rem, div_quo, 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = div_hi_final;
                    lo_d    = div_lo_final;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they come straight from flops.
    always_comb begin
        busy_d = (state_d == S_MULT) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and status registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 65'd0;
            m_q     <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/mult_div.md
# mult_div

Multicycle signed multiply/divide unit for the multicycle datapath. It consumes the same A and B register operands that feed the ALU operand multiplexers, and runs MIPS `mult`/`div` over 33 cycles under control-unit handshake. Results land in the architectural HI/LO registers, which later feed the `mfhi`/`mflo` write-back path. The control unit holds the datapath in a wait state while `busy` is high and resumes on `done`.

## Interface
- No parameters; width fixed at 32 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- a  input  32  operand A (multiplicand / dividend), two's complement.
- b  input  32  operand B (multiplier / divisor), two's complement.
- start_mult  input  1  request signed multiply; sampled only in IDLE.
- start_div  input  1  request signed divide; sampled only in IDLE.
- busy  output  1  high while an operation is iterating.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse coincident with `done` when the divisor was zero.
- hi  output  32  HI register: product[63:32] or remainder.
- lo  output  32  LO register: product[31:0] or quotient.

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - start_mult=1 → latch a, b; clear 5-bit counter; go to MULT.
  - Else start_div=1 and b≠0 → latch a, b; go to DIV.
  - Else start_div=1 and b=0 → go to DONE with div_zero set; hi/lo unchanged.
  - If both starts are high, multiply wins; start_div is dropped.
- MULT: radix-2 Booth, one step per cycle, 32 steps on a 65-bit accumulator {P[63:0], q-1}. After step 32, write hi/lo and go to DONE.
- DIV: restoring divide on operand magnitudes, one quotient bit per cycle, 32 steps.
  - Quotient sign is sign(a)^sign(b); remainder sign follows the dividend; quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000 (wraps, no trap).
- DONE: done=1 for one cycle, then go to IDLE.
- Starts arriving in MULT, DIV or DONE are ignored, not queued.
- a and b may change after the start cycle; only the latched copies are used.
- hi/lo hold their value until the next successful completion. A divide-by-zero does not update them.

## Timing
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Normal operation:
  - busy=1 in cycles 1–32.
  - hi/lo update at the edge ending cycle 32 and are valid in cycle 33.
  - done=1 in cycle 33; busy=0 in cycle 33.
  - IDLE in cycle 34, which is the earliest next accepted start.
- Divide by zero: done=1 and div_zero=1 in cycle 1; busy never asserts; IDLE in cycle 2.
- busy, done and div_zero are registered, with no combinational path from inputs.
- Reset asserted mid-operation: immediately forces all reset values and aborts the operation. No done is produced. The first start after rst_n deasserts behaves normally.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3) → cycle 33: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly in cycles 1–32.
- Multiply 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- Signed divides:
  - 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 100 / 7 → lo=14, hi=2.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero:
  - Preload hi/lo via 3×5 (hi=0, lo=15).
  - Then start divide 9/0 → cycle 1: done=1, div_zero=1, busy=0; hi=0, lo=15 unchanged.
- Start collisions:
  - start_mult and start_div both high with a=6, b=4 → multiply runs, lo=24.
  - Pulse start_div at cycle 10 mid-operation → ignored; exactly one done, at cycle 33.
- Reset and recovery:
  - Start multiply, drop rst_n at cycle 10 → all outputs 0; no done appears.
  - Release rst_n, start 2 × 3 → lo=6 after 33 cycles.
